// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;

    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring shift-subtract steps on
// operand magnitudes, sign fix-up at completion, one-cycle registered write-back.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wr_reg,
    output logic            wr_en
);

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
    logic [4:0]        wr_reg_q, wr_reg_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    // Shared 33-bit adder/subtractor; bit XLEN+1 is the no-borrow flag when subtracting.
    logic              as_sub;
    logic [XLEN:0]     as_a, as_b;
    logic [XLEN+1:0]   as_sum;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        as_sub = f3_q[2];
        as_a   = as_sub ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
        as_b   = {1'b0, b_q};
        as_sum = {1'b0, as_a} + {1'b0, (as_sub ? ~as_b : as_b)} + {{(XLEN+1){1'b0}}, as_sub};
        if (!as_sub) begin
            acc_step = acc_q[0] ? {as_sum[XLEN:0], acc_q[XLEN-1:1]}
                                : {1'b0, acc_q[2*XLEN-1:1]};
        end else begin
            acc_step = as_sum[XLEN+1] ? {as_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                      : {acc_q[2*XLEN-2:0], 1'b0};
        end
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, final_res, dividend, early_res;
    logic              div_zero, sgn_ovf;

    always_comb begin
        prod_s = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
        quot_s = (neg_a_q ^ neg_b_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_s  = neg_a_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                        final_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               final_res = quot_s;
            F3_REM, F3_REMU:               final_res = rem_s;
            default:                       final_res = '0;
        endcase

        // In the first RUN cycle the low half of acc still holds the dividend magnitude.
        dividend  = neg_a_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        div_zero  = f3_q[2] && (b_q == '0);
        sgn_ovf   = (f3_q == F3_DIV || f3_q == F3_REM) && neg_a_q && neg_b_q
                    && (acc_q[XLEN-1:0] == MinNeg) && (b_q == XLEN'(1));
        if (div_zero) begin
            early_res = f3_q[1] ? dividend : '1;
        end else begin
            early_res = f3_q[1] ? '0 : MinNeg;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        b_d      = b_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = '0;
        wr_reg_d = '0;
        wr_en_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    f3_d    = funct3;
                    rd_d    = rd;
                    neg_a_d = rs1_is_signed(funct3) && rs1_data[XLEN-1];
                    neg_b_d = rs2_is_signed(funct3) && rs2_data[XLEN-1];
                    b_d     = magnitude(rs2_data, rs2_is_signed(funct3));
                    acc_d   = {{XLEN{1'b0}}, magnitude(rs1_data, rs1_is_signed(funct3))};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (kill) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == '0 && (div_zero || sgn_ovf)) begin
                    done_d   = 1'b1;
                    result_d = early_res;
                    wr_reg_d = rd_q;
                    wr_en_d  = (rd_q != '0);
                    state_d  = DONE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == ITER_LAST) begin
                        done_d   = 1'b1;
                        result_d = final_res;
                        wr_reg_d = rd_q;
                        wr_en_d  = (rd_q != '0);
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            b_q      <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            wr_reg_q <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            b_q      <= b_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            wr_reg_q <= wr_reg_d;
            wr_en_q  <= wr_en_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign wr_reg = wr_reg_q;
    assign wr_en  = wr_en_q;

endmodule
